program_loader: RTL and testbench

Upstream companion to the instruction execution unit: consumes a byte stream from the debug UART receiver, assembles 32-bit instruction words, writes them into instruction memory, and drives the core's `run` and reset controls. This lets the host reprogram and restart the core without re-synthesis. It sits between the UART RX and the instruction memory write port / core control pins, and returns a one-byte ACK/NAK per command to the UART TX.

---
 rtl/loader_pkg.sv | 18 +
 rtl/loader_timeout.sv | 31 +++
 rtl/program_loader.sv | 208 ++++++++++++++++++++
 tb/tb_program_loader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and protocol byte values for the program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CSUM
    } state_t;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STOP = 8'h53;
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte idle counter; expired is high in the cycle the idle limit is reached
// unless a byte (kick) arrives in that same cycle.
module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic kick,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    assign expired = enable && !kick && (count == CW'(TIMEOUT_CYCLES - 1));

    // NOTE: sequential state is updated only with non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (kick || !enable) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// UART-driven instruction memory loader and core run/reset controller.
// Build option: define LOADER_CHECKSUM_EN to require a trailing zero-sum checksum byte on 'L'.
module program_loader
    import loader_pkg::*;
#(
    parameter int INSTR_WIDTH      = 32,
    parameter int INSTR_ADDR_WIDTH = 16,
    parameter int TIMEOUT_CYCLES   = 1_000_000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_valid,
    output logic [INSTR_ADDR_WIDTH-1:0] imem_addr,
    output logic [INSTR_WIDTH-1:0]      imem_dout,
    output logic                        imem_wr,
    output logic                        core_run,
    output logic                        core_rst,
    output logic [7:0]                  tx_data,
    output logic                        tx_valid,
    output logic                        err
);

    state_t                 state, state_nxt;
    logic [15:0]            len_q;
    logic [15:0]            word_cnt;
    logic [1:0]             byte_idx;
    logic [INSTR_WIDTH-9:0] shift_q;
    logic                   run_pending;
    logic                   timeout;

    logic ack_evt, nak_evt, load_start, load_end, load_ok, run_cmd, stop_cmd;
    logic data_byte, word_done;

    loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .kick    (rx_valid),
        .enable  (state != ST_IDLE),
        .expired (timeout)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum_q;
    logic [7:0] csum_sum;

    assign csum_sum = csum_q + rx_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_q <= '0;
        end else if (load_start) begin
            csum_q <= '0;
        end else if (rx_valid && (state == ST_LEN_LO || state == ST_LEN_HI || state == ST_DATA)) begin
            csum_q <= csum_sum;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // NOTE: every signal written here gets a default first, so no path can leave it
    // unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        ack_evt    = 1'b0;
        nak_evt    = 1'b0;
        load_start = 1'b0;
        load_end   = 1'b0;
        load_ok    = 1'b0;
        run_cmd    = 1'b0;
        stop_cmd   = 1'b0;
        data_byte  = 1'b0;
        word_done  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        CMD_LOAD: begin
                            load_start = 1'b1;
                            state_nxt  = ST_LEN_LO;
                        end
                        CMD_RUN:  run_cmd = 1'b1;
                        CMD_STOP: begin
                            stop_cmd = 1'b1;
                            ack_evt  = 1'b1;
                        end
                        default:  nak_evt = 1'b1;
                    endcase
                end
            end
            ST_LEN_LO: if (rx_valid) state_nxt = ST_LEN_HI;
            ST_LEN_HI: begin
                if (rx_valid) begin
                    if ({rx_data, len_q[7:0]} == 16'd0) load_end  = 1'b1;
                    else                                state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    data_byte = 1'b1;
                    if (byte_idx == 2'd3) begin
                        word_done = 1'b1;
                        load_end  = (word_cnt + 16'd1 == len_q);
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (rx_valid) begin
                    state_nxt = ST_IDLE;
                    if (csum_sum == 8'h00) begin
                        ack_evt = 1'b1;
                        load_ok = 1'b1;
                    end else begin
                        nak_evt = 1'b1;
                    end
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase

        if (load_end) begin
`ifdef LOADER_CHECKSUM_EN
            state_nxt = ST_CSUM;
`else
            state_nxt = ST_IDLE;
            ack_evt   = 1'b1;
            load_ok   = 1'b1;
`endif
        end

        // Timeout only fires on an idle cycle; the sub-module already masks it on rx_valid.
        if (timeout) begin
            nak_evt   = 1'b1;
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q       <= '0;
            word_cnt    <= '0;
            byte_idx    <= '0;
            shift_q     <= '0;
            run_pending <= 1'b0;
            imem_addr   <= '0;
            imem_dout   <= '0;
            imem_wr     <= 1'b0;
            core_run    <= 1'b0;
            core_rst    <= 1'b0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            err         <= 1'b0;
        end else begin
            imem_wr  <= 1'b0;
            core_rst <= 1'b0;
            tx_valid <= 1'b0;

            // Second half of 'R': the core has seen one reset cycle, now let it run.
            if (run_pending) begin
                run_pending <= 1'b0;
                core_run    <= 1'b1;
                tx_data     <= RSP_ACK;
                tx_valid    <= 1'b1;
            end
            if (run_cmd) begin
                core_rst    <= 1'b1;
                run_pending <= 1'b1;
            end
            if (stop_cmd || load_start) begin
                core_run    <= 1'b0;
                run_pending <= 1'b0;
            end
            if (load_start) begin
                word_cnt <= '0;
                byte_idx <= '0;
            end

            if (rx_valid && state == ST_LEN_LO) len_q[7:0]  <= rx_data;
            if (rx_valid && state == ST_LEN_HI) len_q[15:8] <= rx_data;

            if (data_byte) begin
                byte_idx <= byte_idx + 2'd1;
                shift_q  <= {rx_data, shift_q[INSTR_WIDTH-9:8]};
            end
            if (word_done) begin
                imem_wr   <= 1'b1;
                imem_addr <= INSTR_ADDR_WIDTH'(word_cnt);
                imem_dout <= {rx_data, shift_q};
                word_cnt  <= word_cnt + 16'd1;
            end

            if (ack_evt || nak_evt) begin
                tx_valid <= 1'b1;
                tx_data  <= nak_evt ? RSP_NAK : RSP_ACK;
            end
            if (nak_evt)      err <= 1'b1;
            else if (load_ok) err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader; honours LOADER_CHECKSUM_EN when defined.
module tb_program_loader;

    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] imem_addr;
    logic [31:0] imem_dout;
    logic        imem_wr;
    logic        core_run;
    logic        core_rst;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        err;

    int passed   = 0;
    int failed   = 0;
    int total    = 0;
    int wr_count = 0;
    int n;

    program_loader #(
        .INSTR_WIDTH      (32),
        .INSTR_ADDR_WIDTH (16),
        .TIMEOUT_CYCLES   (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .imem_addr (imem_addr),
        .imem_dout (imem_dout),
        .imem_wr   (imem_wr),
        .core_run  (core_run),
        .core_rst  (core_rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst === 1'b1 && imem_wr === 1'b1) wr_count++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #1;
        tick();
        tick();
        check("rst_imem_wr",   imem_wr,   0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_imem_dout", imem_dout, 0);
        check("rst_core_run",  core_run,  0);
        check("rst_core_rst",  core_rst,  0);
        check("rst_tx_valid",  tx_valid,  0);
        check("rst_tx_data",   tx_data,   0);
        check("rst_err",       err,       0);
        rst = 1'b1;
        tick();

        // Run: reset pulse at +1, run and ACK at +2
        send(8'h52);
        check("r_core_rst_p1", core_rst, 1);
        check("r_core_run_p1", core_run, 0);
        check("r_tx_valid_p1", tx_valid, 0);
        tick();
        check("r_core_rst_p2", core_rst, 0);
        check("r_core_run_p2", core_run, 1);
        check("r_tx_valid_p2", tx_valid, 1);
        check("r_tx_data_p2",  tx_data,  8'h06);
        tick();
        check("r_tx_valid_p3", tx_valid, 0);

        // Stop
        send(8'h53);
        check("s_core_run",  core_run, 0);
        check("s_tx_valid",  tx_valid, 1);
        check("s_tx_data",   tx_data,  8'h06);
        tick();

        // Run again, then 'L' must drop core_run at once
        send(8'h52);
        tick();
        check("r2_core_run", core_run, 1);
        send(8'h4C);
        check("l_clears_run", core_run, 0);
        check("l_no_tx",      tx_valid, 0);
        send(8'h02); send(8'h00);
        send(8'h78); send(8'h56); send(8'h34);
        check("w0_not_yet", imem_wr, 0);
        send(8'h12);
        check("w0_wr",   imem_wr,   1);
        check("w0_addr", imem_addr, 0);
        check("w0_data", imem_dout, 32'h12345678);
        check("w0_no_tx", tx_valid, 0);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        check("w1_wr",   imem_wr,   1);
        check("w1_addr", imem_addr, 1);
        check("w1_data", imem_dout, 32'hDEADBEEF);
`ifdef LOADER_CHECKSUM_EN
        check("w1_wait_csum", tx_valid, 0);
        send(8'hB2);
`endif
        check("l2_ack_valid", tx_valid, 1);
        check("l2_ack_data",  tx_data,  8'h06);
        check("l2_err",       err,      0);
        tick();

        // Zero-length load
        send(8'h4C); send(8'h00); send(8'h00);
`ifdef LOADER_CHECKSUM_EN
        send(8'h00);
`endif
        check("l0_ack_valid", tx_valid, 1);
        check("l0_ack_data",  tx_data,  8'h06);
        tick();
        tick();
        check("l0_no_write", wr_count, 2);

        // Timeout mid-word
        send(8'h4C); send(8'h01); send(8'h00); send(8'hAA);
        n = 0;
        while (tx_valid !== 1'b1 && n < TO + 20) begin
            tick();
            n++;
        end
        check("to_latency", n,       TO);
        check("to_nak",     tx_data, 8'h15);
        check("to_err",     err,     1);
        tick();
        tick();
        check("to_no_write", wr_count, 2);

        // Byte in the would-be timeout cycle is accepted; good load clears err
        send(8'h4C); send(8'h01); send(8'h00);
        repeat (TO - 1) tick();
        send(8'h11);
        check("late_byte_no_nak", tx_valid, 0);
        send(8'h22); send(8'h33); send(8'h44);
        check("late_wr",   imem_wr,   1);
        check("late_addr", imem_addr, 0);
        check("late_data", imem_dout, 32'h44332211);
`ifdef LOADER_CHECKSUM_EN
        send(8'h55);
`endif
        check("late_ack",     tx_data, 8'h06);
        check("late_ack_vld", tx_valid, 1);
        check("late_err_clr", err,      0);
        tick();

        // Unknown command
        send(8'h41);
        check("bad_cmd_vld", tx_valid, 1);
        check("bad_cmd_nak", tx_data,  8'h15);
        check("bad_cmd_err", err,      1);
        tick();
        send(8'h53);
        check("idle_after_nak", tx_data, 8'h06);
        check("err_sticky",     err,     1);
        tick();

`ifdef LOADER_CHECKSUM_EN
        n = wr_count;
        send(8'h4C); send(8'h02); send(8'h00);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        send(8'hB3);
        check("csum_nak", tx_data, 8'h15);
        check("csum_err", err,     1);
        tick();
        check("csum_words_written", wr_count - n, 2);
        tick();
`endif

        // Reset in the middle of the second word
        send(8'h4C); send(8'h02); send(8'h00);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h05); send(8'h06);
        rst = 1'b0;
        #1;
        check("mid_rst_err",  err,       0);
        check("mid_rst_addr", imem_addr, 0);
        check("mid_rst_data", imem_dout, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_tx",   tx_valid, 0);
        check("post_rst_run",  core_run, 0);
        check("post_rst_txd",  tx_data,  0);
        send(8'h4C); send(8'h01); send(8'h00);
        send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4);
        check("reload_wr",   imem_wr,   1);
        check("reload_addr", imem_addr, 0);
        check("reload_data", imem_dout, 32'hD4C3B2A1);
`ifdef LOADER_CHECKSUM_EN
        send(8'h15);
`endif
        check("reload_ack", tx_data, 8'h06);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
